// File: rtl/multicycle_control_unit.sv
// Multicycle MIPS control FSM. Each instruction is sequenced over several
// cycles: FETCH, DECODE, then a per-class execute/memory/write-back path.
// The unit drives a shared-memory datapath and counts retired instructions.
//
// Memory handshake: the unit holds mem_read or mem_write high with a stable
// address select. The access completes on the first cycle mem_ready is high.
// Until then the unit keeps the same state and keeps its requests asserted.
// With MEM_HANDSHAKE=0, mem_ready is ignored and every access completes in
// one cycle.
module multicycle_control_unit #(
  parameter int MEM_HANDSHAKE = 1,
  parameter int SUPPORT_IMM   = 1,
  parameter int CNT_W         = 32
) (
  input  logic             clk,
  input  logic             reset,
  input  logic [5:0]       opcode,
  input  logic             mem_ready,
  output logic             pc_write,
  output logic             pc_write_cond,
  output logic             i_or_d,
  output logic             mem_read,
  output logic             mem_write,
  output logic             ir_write,
  output logic             mem_to_reg,
  output logic             reg_dst,
  output logic             reg_write,
  output logic             alu_src_a,
  output logic [1:0]       alu_src_b,
  output logic [1:0]       alu_op,
  output logic [1:0]       pc_source,
  output logic             instr_done,
  output logic             illegal_op,
  output logic [CNT_W-1:0] instr_count,
  output logic [3:0]       state
);

  typedef enum logic [3:0] {
    S_FETCH    = 4'd0,
    S_DECODE   = 4'd1,
    S_MEM_ADDR = 4'd2,
    S_MEM_RD   = 4'd3,
    S_MEM_WB   = 4'd4,
    S_MEM_WR   = 4'd5,
    S_R_EXEC   = 4'd6,
    S_R_WB     = 4'd7,
    S_I_EXEC   = 4'd8,
    S_I_WB     = 4'd9,
    S_BRANCH   = 4'd10,
    S_JUMP     = 4'd11
  } state_t;

  localparam logic [5:0] OP_RTYPE = 6'h00;
  localparam logic [5:0] OP_J     = 6'h02;
  localparam logic [5:0] OP_BEQ   = 6'h04;
  localparam logic [5:0] OP_ADDI  = 6'h08;
  localparam logic [5:0] OP_SLTI  = 6'h0A;
  localparam logic [5:0] OP_ANDI  = 6'h0C;
  localparam logic [5:0] OP_ORI   = 6'h0D;
  localparam logic [5:0] OP_LW    = 6'h23;
  localparam logic [5:0] OP_SW    = 6'h2B;

  state_t state_q;
  state_t state_d;
  state_t out_state;
  logic   ready_eff;
  logic   is_imm;

  assign ready_eff = (MEM_HANDSHAKE != 0) ? mem_ready : 1'b1;
  assign is_imm    = (SUPPORT_IMM != 0) &&
                     ((opcode == OP_ADDI) || (opcode == OP_ANDI) ||
                      (opcode == OP_ORI)  || (opcode == OP_SLTI));

  // Outputs decode FETCH while reset is high, so a mid-instruction reset
  // never issues a write or a retire in the reset cycle.
  assign out_state = reset ? S_FETCH : state_q;
  assign state     = state_q;

  // State register.
  always_ff @(posedge clk) begin
    if (reset) state_q <= S_FETCH;
    else       state_q <= state_d;
  end

  // Retire counter. It wraps modulo 2^CNT_W.
  always_ff @(posedge clk) begin
    if (reset)           instr_count <= '0;
    else if (instr_done) instr_count <= instr_count + {{(CNT_W-1){1'b0}}, 1'b1};
  end

  // Next-state and control outputs.
  always_comb begin
    state_d       = S_FETCH;
    pc_write      = 1'b0;
    pc_write_cond = 1'b0;
    i_or_d        = 1'b0;
    mem_read      = 1'b0;
    mem_write     = 1'b0;
    ir_write      = 1'b0;
    mem_to_reg    = 1'b0;
    reg_dst       = 1'b0;
    reg_write     = 1'b0;
    alu_src_a     = 1'b0;
    alu_src_b     = 2'b00;
    alu_op        = 2'b00;
    pc_source     = 2'b00;
    instr_done    = 1'b0;
    illegal_op    = 1'b0;
    case (out_state)
      S_FETCH: begin
        mem_read  = 1'b1;
        alu_src_b = 2'b01;
        ir_write  = ready_eff;
        pc_write  = ready_eff;
        state_d   = ready_eff ? S_DECODE : S_FETCH;
      end
      S_DECODE: begin
        // Branch target (PC+4 + imm<<2) is latched into ALUOut here.
        alu_src_b = 2'b11;
        if ((opcode == OP_LW) || (opcode == OP_SW)) state_d = S_MEM_ADDR;
        else if (opcode == OP_RTYPE)                state_d = S_R_EXEC;
        else if (is_imm)                            state_d = S_I_EXEC;
        else if (opcode == OP_BEQ)                  state_d = S_BRANCH;
        else if (opcode == OP_J)                    state_d = S_JUMP;
        else begin
          illegal_op = 1'b1;
          state_d    = S_FETCH;
        end
      end
      S_MEM_ADDR: begin
        alu_src_a = 1'b1;
        alu_src_b = 2'b10;
        if (opcode == OP_LW)      state_d = S_MEM_RD;
        else if (opcode == OP_SW) state_d = S_MEM_WR;
        else                      state_d = S_FETCH;
      end
      S_MEM_RD: begin
        mem_read = 1'b1;
        i_or_d   = 1'b1;
        state_d  = ready_eff ? S_MEM_WB : S_MEM_RD;
      end
      S_MEM_WB: begin
        reg_write  = 1'b1;
        mem_to_reg = 1'b1;
        instr_done = 1'b1;
        state_d    = S_FETCH;
      end
      S_MEM_WR: begin
        mem_write  = 1'b1;
        i_or_d     = 1'b1;
        instr_done = ready_eff;
        state_d    = ready_eff ? S_FETCH : S_MEM_WR;
      end
      S_R_EXEC: begin
        alu_src_a = 1'b1;
        alu_op    = 2'b10;
        state_d   = S_R_WB;
      end
      S_R_WB: begin
        reg_write  = 1'b1;
        reg_dst    = 1'b1;
        instr_done = 1'b1;
        state_d    = S_FETCH;
      end
      S_I_EXEC: begin
        alu_src_a = 1'b1;
        alu_src_b = 2'b10;
        alu_op    = (opcode == OP_ADDI) ? 2'b00 : 2'b11;
        state_d   = S_I_WB;
      end
      S_I_WB: begin
        reg_write  = 1'b1;
        instr_done = 1'b1;
        state_d    = S_FETCH;
      end
      S_BRANCH: begin
        alu_src_a     = 1'b1;
        alu_op        = 2'b01;
        pc_write_cond = 1'b1;
        pc_source     = 2'b01;
        instr_done    = 1'b1;
        state_d       = S_FETCH;
      end
      S_JUMP: begin
        pc_write   = 1'b1;
        pc_source  = 2'b10;
        instr_done = 1'b1;
        state_d    = S_FETCH;
      end
      default: state_d = S_FETCH;
    endcase
  end

endmodule

// File: tb/tb_multicycle_control_unit.sv
// Directed bench for multicycle_control_unit. Four instances cover the
// default build, SUPPORT_IMM=0, MEM_HANDSHAKE=0 and CNT_W=4. The bench
// changes inputs 1 time unit after a rising edge and samples outputs 1 time
// unit later. Expected control words are written out per state below.
module tb_multicycle_control_unit;

  logic clk = 1'b0;
  always #5 clk = ~clk;

  logic       rst  [4];
  logic [5:0] op   [4];
  logic       rdy  [4];

  logic       pc_write_s      [4];
  logic       pc_write_cond_s [4];
  logic       i_or_d_s        [4];
  logic       mem_read_s      [4];
  logic       mem_write_s     [4];
  logic       ir_write_s      [4];
  logic       mem_to_reg_s    [4];
  logic       reg_dst_s       [4];
  logic       reg_write_s     [4];
  logic       alu_src_a_s     [4];
  logic [1:0] alu_src_b_s     [4];
  logic [1:0] alu_op_s        [4];
  logic [1:0] pc_source_s     [4];
  logic       instr_done_s    [4];
  logic       illegal_op_s    [4];
  logic [3:0] state_s         [4];
  logic [31:0] cnt [3];
  logic [3:0]  cnt4;

  int n_cmp = 0;
  int n_bad = 0;

  multicycle_control_unit u0 (
    .clk(clk), .reset(rst[0]), .opcode(op[0]), .mem_ready(rdy[0]),
    .pc_write(pc_write_s[0]), .pc_write_cond(pc_write_cond_s[0]), .i_or_d(i_or_d_s[0]),
    .mem_read(mem_read_s[0]), .mem_write(mem_write_s[0]), .ir_write(ir_write_s[0]),
    .mem_to_reg(mem_to_reg_s[0]), .reg_dst(reg_dst_s[0]), .reg_write(reg_write_s[0]),
    .alu_src_a(alu_src_a_s[0]), .alu_src_b(alu_src_b_s[0]), .alu_op(alu_op_s[0]),
    .pc_source(pc_source_s[0]), .instr_done(instr_done_s[0]), .illegal_op(illegal_op_s[0]),
    .instr_count(cnt[0]), .state(state_s[0]));

  multicycle_control_unit #(.SUPPORT_IMM(0)) u1 (
    .clk(clk), .reset(rst[1]), .opcode(op[1]), .mem_ready(rdy[1]),
    .pc_write(pc_write_s[1]), .pc_write_cond(pc_write_cond_s[1]), .i_or_d(i_or_d_s[1]),
    .mem_read(mem_read_s[1]), .mem_write(mem_write_s[1]), .ir_write(ir_write_s[1]),
    .mem_to_reg(mem_to_reg_s[1]), .reg_dst(reg_dst_s[1]), .reg_write(reg_write_s[1]),
    .alu_src_a(alu_src_a_s[1]), .alu_src_b(alu_src_b_s[1]), .alu_op(alu_op_s[1]),
    .pc_source(pc_source_s[1]), .instr_done(instr_done_s[1]), .illegal_op(illegal_op_s[1]),
    .instr_count(cnt[1]), .state(state_s[1]));

  multicycle_control_unit #(.MEM_HANDSHAKE(0)) u2 (
    .clk(clk), .reset(rst[2]), .opcode(op[2]), .mem_ready(rdy[2]),
    .pc_write(pc_write_s[2]), .pc_write_cond(pc_write_cond_s[2]), .i_or_d(i_or_d_s[2]),
    .mem_read(mem_read_s[2]), .mem_write(mem_write_s[2]), .ir_write(ir_write_s[2]),
    .mem_to_reg(mem_to_reg_s[2]), .reg_dst(reg_dst_s[2]), .reg_write(reg_write_s[2]),
    .alu_src_a(alu_src_a_s[2]), .alu_src_b(alu_src_b_s[2]), .alu_op(alu_op_s[2]),
    .pc_source(pc_source_s[2]), .instr_done(instr_done_s[2]), .illegal_op(illegal_op_s[2]),
    .instr_count(cnt[2]), .state(state_s[2]));

  multicycle_control_unit #(.CNT_W(4)) u3 (
    .clk(clk), .reset(rst[3]), .opcode(op[3]), .mem_ready(rdy[3]),
    .pc_write(pc_write_s[3]), .pc_write_cond(pc_write_cond_s[3]), .i_or_d(i_or_d_s[3]),
    .mem_read(mem_read_s[3]), .mem_write(mem_write_s[3]), .ir_write(ir_write_s[3]),
    .mem_to_reg(mem_to_reg_s[3]), .reg_dst(reg_dst_s[3]), .reg_write(reg_write_s[3]),
    .alu_src_a(alu_src_a_s[3]), .alu_src_b(alu_src_b_s[3]), .alu_op(alu_op_s[3]),
    .pc_source(pc_source_s[3]), .instr_done(instr_done_s[3]), .illegal_op(illegal_op_s[3]),
    .instr_count(cnt4), .state(state_s[3]));

  // Control word: {pc_write, pc_write_cond, i_or_d, mem_read, mem_write,
  // ir_write, mem_to_reg, reg_dst, reg_write, alu_src_a, alu_src_b[1:0],
  // alu_op[1:0], pc_source[1:0], instr_done, illegal_op}
  localparam logic [17:0] K_PCW  = 18'd1 << 17;
  localparam logic [17:0] K_PCWC = 18'd1 << 16;
  localparam logic [17:0] K_IORD = 18'd1 << 15;
  localparam logic [17:0] K_MRD  = 18'd1 << 14;
  localparam logic [17:0] K_MWR  = 18'd1 << 13;
  localparam logic [17:0] K_IRW  = 18'd1 << 12;
  localparam logic [17:0] K_M2R  = 18'd1 << 11;
  localparam logic [17:0] K_RDST = 18'd1 << 10;
  localparam logic [17:0] K_RW   = 18'd1 << 9;
  localparam logic [17:0] K_SRCA = 18'd1 << 8;
  localparam logic [17:0] K_SB01 = 18'd1 << 6;
  localparam logic [17:0] K_SB10 = 18'd2 << 6;
  localparam logic [17:0] K_SB11 = 18'd3 << 6;
  localparam logic [17:0] K_OP01 = 18'd1 << 4;
  localparam logic [17:0] K_OP10 = 18'd2 << 4;
  localparam logic [17:0] K_OP11 = 18'd3 << 4;
  localparam logic [17:0] K_PS01 = 18'd1 << 2;
  localparam logic [17:0] K_PS10 = 18'd2 << 2;
  localparam logic [17:0] K_DONE = 18'd1 << 1;
  localparam logic [17:0] K_ILL  = 18'd1;

  localparam logic [17:0] E_F_NRDY   = K_MRD | K_SB01;
  localparam logic [17:0] E_F_RDY    = K_MRD | K_SB01 | K_PCW | K_IRW;
  localparam logic [17:0] E_DEC      = K_SB11;
  localparam logic [17:0] E_DEC_ILL  = K_SB11 | K_ILL;
  localparam logic [17:0] E_MADDR    = K_SRCA | K_SB10;
  localparam logic [17:0] E_MRD      = K_MRD | K_IORD;
  localparam logic [17:0] E_MWB      = K_RW | K_M2R | K_DONE;
  localparam logic [17:0] E_MWR_N    = K_MWR | K_IORD;
  localparam logic [17:0] E_MWR_R    = K_MWR | K_IORD | K_DONE;
  localparam logic [17:0] E_REX      = K_SRCA | K_OP10;
  localparam logic [17:0] E_RWB      = K_RW | K_RDST | K_DONE;
  localparam logic [17:0] E_IEX_ADD  = K_SRCA | K_SB10;
  localparam logic [17:0] E_IEX_LOG  = K_SRCA | K_SB10 | K_OP11;
  localparam logic [17:0] E_IWB      = K_RW | K_DONE;
  localparam logic [17:0] E_BR       = K_SRCA | K_OP01 | K_PCWC | K_PS01 | K_DONE;
  localparam logic [17:0] E_JMP      = K_PCW | K_PS10 | K_DONE;

  function automatic logic [17:0] ctl(input int i);
    ctl = {pc_write_s[i], pc_write_cond_s[i], i_or_d_s[i], mem_read_s[i],
           mem_write_s[i], ir_write_s[i], mem_to_reg_s[i], reg_dst_s[i],
           reg_write_s[i], alu_src_a_s[i], alu_src_b_s[i], alu_op_s[i],
           pc_source_s[i], instr_done_s[i], illegal_op_s[i]};
  endfunction

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_cmp++;
    assert (obs === exp) else begin
      n_bad++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  // Check one cycle of instance i (state and control word), then advance.
  task automatic cyc(input int i, input string tag, input logic [3:0] exp_state,
                     input logic [17:0] exp_ctl);
    #1;
    chk({tag, ".state"}, {28'd0, state_s[i]}, {28'd0, exp_state});
    chk({tag, ".ctl"},   {14'd0, ctl(i)},     {14'd0, exp_ctl});
    tick();
  endtask

  initial begin
    for (int i = 0; i < 4; i++) begin
      rst[i] = 1'b1;
      op[i]  = 6'h00;
      rdy[i] = 1'b0;
    end
    tick();
    tick();

    // Reset state of the default instance.
    #1;
    chk("reset.state", {28'd0, state_s[0]}, 32'd0);
    chk("reset.ctl",   {14'd0, ctl(0)},     {14'd0, E_F_NRDY});
    chk("reset.count", cnt[0],              32'd0);
    tick();

    // R-type, zero wait.
    rst[0] = 1'b0; rdy[0] = 1'b1; op[0] = 6'h00;
    cyc(0, "rtype.f",  4'd0, E_F_RDY);
    cyc(0, "rtype.d",  4'd1, E_DEC);
    cyc(0, "rtype.ex", 4'd6, E_REX);
    cyc(0, "rtype.wb", 4'd7, E_RWB);
    #1;
    chk("rtype.count", cnt[0], 32'd1);
    chk("rtype.back",  {28'd0, state_s[0]}, 32'd0);

    // LW with two wait cycles in MEM_RD.
    op[0] = 6'h23;
    cyc(0, "lw.f",    4'd0, E_F_RDY);
    cyc(0, "lw.d",    4'd1, E_DEC);
    cyc(0, "lw.addr", 4'd2, E_MADDR);
    rdy[0] = 1'b0;
    cyc(0, "lw.rd0",  4'd3, E_MRD);
    cyc(0, "lw.rd1",  4'd3, E_MRD);
    rdy[0] = 1'b1;
    cyc(0, "lw.rd2",  4'd3, E_MRD);
    cyc(0, "lw.wb",   4'd4, E_MWB);
    #1;
    chk("lw.count", cnt[0], 32'd2);

    // BEQ then J.
    op[0] = 6'h04;
    cyc(0, "beq.f",  4'd0, E_F_RDY);
    cyc(0, "beq.d",  4'd1, E_DEC);
    cyc(0, "beq.br", 4'd10, E_BR);
    op[0] = 6'h02;
    cyc(0, "j.f",    4'd0, E_F_RDY);
    cyc(0, "j.d",    4'd1, E_DEC);
    cyc(0, "j.jmp",  4'd11, E_JMP);
    #1;
    chk("bj.count", cnt[0], 32'd4);

    // ANDI and ADDI select different ALU ops.
    op[0] = 6'h0C;
    cyc(0, "andi.f",  4'd0, E_F_RDY);
    cyc(0, "andi.d",  4'd1, E_DEC);
    cyc(0, "andi.ex", 4'd8, E_IEX_LOG);
    cyc(0, "andi.wb", 4'd9, E_IWB);
    op[0] = 6'h08;
    cyc(0, "addi.f",  4'd0, E_F_RDY);
    cyc(0, "addi.d",  4'd1, E_DEC);
    cyc(0, "addi.ex", 4'd8, E_IEX_ADD);
    cyc(0, "addi.wb", 4'd9, E_IWB);
    #1;
    chk("imm.count", cnt[0], 32'd6);

    // SW with a fetch stall and one write wait.
    op[0] = 6'h2B; rdy[0] = 1'b0;
    cyc(0, "sw.fwait", 4'd0, E_F_NRDY);
    rdy[0] = 1'b1;
    cyc(0, "sw.f",     4'd0, E_F_RDY);
    cyc(0, "sw.d",     4'd1, E_DEC);
    cyc(0, "sw.addr",  4'd2, E_MADDR);
    rdy[0] = 1'b0;
    cyc(0, "sw.wwait", 4'd5, E_MWR_N);
    rdy[0] = 1'b1;
    cyc(0, "sw.wr",    4'd5, E_MWR_R);
    #1;
    chk("sw.count", cnt[0], 32'd7);

    // Illegal opcode: no retire.
    op[0] = 6'h3F;
    cyc(0, "ill.f", 4'd0, E_F_RDY);
    cyc(0, "ill.d", 4'd1, E_DEC_ILL);
    #1;
    chk("ill.state", {28'd0, state_s[0]}, 32'd0);
    chk("ill.count", cnt[0], 32'd7);

    // Reset during a MEM_WR wait.
    op[0] = 6'h2B;
    cyc(0, "rsw.f",    4'd0, E_F_RDY);
    cyc(0, "rsw.d",    4'd1, E_DEC);
    cyc(0, "rsw.addr", 4'd2, E_MADDR);
    rdy[0] = 1'b0;
    cyc(0, "rsw.wait", 4'd5, E_MWR_N);
    rst[0] = 1'b1;
    #1;
    chk("rsw.ctl_in_reset", {14'd0, ctl(0)}, {14'd0, E_F_NRDY});
    tick();
    #1;
    chk("rsw.state", {28'd0, state_s[0]}, 32'd0);
    chk("rsw.count", cnt[0], 32'd0);
    chk("rsw.done",  {31'd0, instr_done_s[0]}, 32'd0);

    // Reset in R_WB suppresses that retire.
    rst[0] = 1'b0; rdy[0] = 1'b1; op[0] = 6'h00;
    cyc(0, "rrw.f",  4'd0, E_F_RDY);
    cyc(0, "rrw.d",  4'd1, E_DEC);
    cyc(0, "rrw.ex", 4'd6, E_REX);
    rst[0] = 1'b1; rdy[0] = 1'b0;
    #1;
    chk("rrw.ctl_in_reset", {14'd0, ctl(0)}, {14'd0, E_F_NRDY});
    tick();
    #1;
    chk("rrw.state", {28'd0, state_s[0]}, 32'd0);
    chk("rrw.count", cnt[0], 32'd0);

    // SUPPORT_IMM=0: ANDI and ORI are illegal.
    rst[1] = 1'b0; rdy[1] = 1'b1; op[1] = 6'h0C;
    cyc(1, "noimm.andi.f", 4'd0, E_F_RDY);
    cyc(1, "noimm.andi.d", 4'd1, E_DEC_ILL);
    op[1] = 6'h0D;
    cyc(1, "noimm.ori.f",  4'd0, E_F_RDY);
    cyc(1, "noimm.ori.d",  4'd1, E_DEC_ILL);
    #1;
    chk("noimm.state", {28'd0, state_s[1]}, 32'd0);
    chk("noimm.count", cnt[1], 32'd0);

    // MEM_HANDSHAKE=0 with mem_ready tied low: SW in 4 cycles.
    rst[2] = 1'b0; rdy[2] = 1'b0; op[2] = 6'h2B;
    cyc(2, "nohs.f",    4'd0, E_F_RDY);
    cyc(2, "nohs.d",    4'd1, E_DEC);
    cyc(2, "nohs.addr", 4'd2, E_MADDR);
    cyc(2, "nohs.wr",   4'd5, E_MWR_R);
    #1;
    chk("nohs.state", {28'd0, state_s[2]}, 32'd0);
    chk("nohs.count", cnt[2], 32'd1);
    rst[2] = 1'b1;

    // CNT_W=4: 16 jumps wrap the counter to zero.
    rst[3] = 1'b0; rdy[3] = 1'b1; op[3] = 6'h02;
    for (int k = 0; k < 15; k++) begin
      tick(); tick(); tick();
    end
    #1;
    chk("wrap.count15", {28'd0, cnt4}, 32'd15);
    cyc(3, "wrap.f",   4'd0, E_F_RDY);
    cyc(3, "wrap.d",   4'd1, E_DEC);
    cyc(3, "wrap.jmp", 4'd11, E_JMP);
    #1;
    chk("wrap.count0", {28'd0, cnt4}, 32'd0);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule

// File: doc/multicycle_control_unit.md
# multicycle_control_unit

Multicycle MIPS control FSM that sequences each instruction over 3–5+ cycles instead of decoding it in a single cycle. It drives the shared-memory multicycle datapath: PC, IR, register file, ALU muxes and one unified memory port with a ready handshake. It also retires an instruction counter. The opcode set is the same as the single-cycle core: R-type, ADDI, ANDI, ORI, SLTI, LW, SW, BEQ and J.

## Interface
- `MEM_HANDSHAKE`, default 1. When 1, memory states wait on `mem_ready`. When 0, `mem_ready` is ignored and treated as 1.
- `SUPPORT_IMM`, default 1. When 0, ADDI, ANDI, ORI and SLTI decode as illegal.
- `CNT_W`, default 32. Width of `instr_count`.
- `clk` in 1: system clock, rising edge.
- `reset` in 1: synchronous, active-high.
- `opcode` in 6: IR[31:26]. Stable from DECODE to the end of the instruction, because the IR is written only in FETCH.
- `mem_ready` in 1: memory completes the current access this cycle.
- `pc_write` out 1: unconditional PC load.
- `pc_write_cond` out 1: PC load if ALU zero.
- `i_or_d` out 1: memory address select, 0=PC, 1=ALUOut.
- `mem_read` out 1: memory read request.
- `mem_write` out 1: memory write request.
- `ir_write` out 1: IR load.
- `mem_to_reg` out 1: write-back data select, 1=MDR.
- `reg_dst` out 1: write register select, 1=rd.
- `reg_write` out 1: register file write.
- `alu_src_a` out 1: ALU A select, 0=PC, 1=A register.
- `alu_src_b` out 2: ALU B select, 00=B, 01=4, 10=sign-ext imm, 11=imm<<2.
- `alu_op` out 2: 00=add, 01=sub, 10=use funct, 11=immediate logical/compare (ALU control decodes opcode).
- `pc_source` out 2: 00=ALU result, 01=ALUOut, 10=jump target.
- `instr_done` out 1: one-cycle pulse when an instruction retires.
- `illegal_op` out 1: one-cycle pulse in DECODE for an unsupported opcode.
- `instr_count` out CNT_W: count of retired instructions.
- `state` out 4: current state, for debug.

## Operation
- State encoding: FETCH=0, DECODE=1, MEM_ADDR=2, MEM_RD=3, MEM_WB=4, MEM_WR=5, R_EXEC=6, R_WB=7, I_EXEC=8, I_WB=9, BRANCH=10, JUMP=11. Codes 12–15 are unreachable and return to FETCH.
- All outputs are 0 unless listed for the current state.
- FETCH:
  - Drives `mem_read`=1, `i_or_d`=0, `alu_src_a`=0, `alu_src_b`=01, `alu_op`=00, `pc_source`=00.
  - `ir_write` = `pc_write` = `mem_ready` (the effective value).
  - Stays in FETCH while not ready; moves to DECODE when ready.
- DECODE:
  - Drives `alu_src_a`=0, `alu_src_b`=11, `alu_op`=00 (branch target into ALUOut).
  - Next state by opcode: LW/SW→MEM_ADDR; R_TYPE→R_EXEC; ADDI/ANDI/ORI/SLTI→I_EXEC; BEQ→BRANCH; J→JUMP.
  - Any other opcode: `illegal_op`=1, next state FETCH, no retire.
- MEM_ADDR: `alu_src_a`=1, `alu_src_b`=10, `alu_op`=00. Next state MEM_RD for LW, MEM_WR for SW.
- MEM_RD: `mem_read`=1, `i_or_d`=1. Waits on ready, then MEM_WB.
- MEM_WB: `reg_write`=1, `mem_to_reg`=1, `reg_dst`=0. Retires, next FETCH.
- MEM_WR: `mem_write`=1, `i_or_d`=1. Waits on ready; retires on the ready cycle, then FETCH.
- R_EXEC: `alu_src_a`=1, `alu_src_b`=00, `alu_op`=10. Next R_WB.
- R_WB: `reg_write`=1, `reg_dst`=1. Retires, next FETCH.
- I_EXEC: `alu_src_a`=1, `alu_src_b`=10, `alu_op`=00 for ADDI, 11 for ANDI/ORI/SLTI. Next I_WB.
- I_WB: `reg_write`=1, `reg_dst`=0, `mem_to_reg`=0. Retires, next FETCH.
- BRANCH: `alu_src_a`=1, `alu_src_b`=00, `alu_op`=01, `pc_write_cond`=1, `pc_source`=01. Retires, next FETCH.
- JUMP: `pc_write`=1, `pc_source`=10. Retires, next FETCH.
- Retire: `instr_done`=1 for that cycle, and `instr_count` increments by 1 on the same edge.
  - Modulo 2^CNT_W: all-ones wraps to 0 with no flag.
  - Illegal opcodes never retire.

## Timing
- `state` and `instr_count` are registered.
- Outputs are combinational from `state`, `opcode` and the effective `mem_ready`. `mem_ready` affects only `ir_write`, `pc_write` in FETCH and `instr_done` in MEM_WR.
- Zero-wait latency, counting FETCH to retire inclusive: BEQ/J 3, R-type/imm/SW 4, LW 5. Each memory wait cycle adds 1.
- Illegal opcode: 2 cycles (FETCH, DECODE), then FETCH.
- Reset:
  - `reset` high at an edge forces `state`=FETCH and `instr_count`=0.
  - It overrides any transition or retire in that same cycle, including mid-instruction and mid-memory-wait.
  - While `reset` is high, outputs reflect FETCH: `mem_read`=1, `alu_src_b`=01, all others 0. `ir_write`/`pc_write` follow ready; the bench holds `mem_ready`=0 during reset.
- `mem_ready` asserted outside FETCH/MEM_RD/MEM_WR has no effect.

## Test plan
- Reset, then R-type (opcode 0x00) with `mem_ready`=1 → states 0,1,6,7,0; `reg_write`=1 and `reg_dst`=1 only in state 7; `instr_done` pulse there; `instr_count`=1.
- LW (0x23) with `mem_ready` low for 2 cycles in MEM_RD → states 0,1,2,3,3,3,4; `mem_read`=1 throughout state 3; `mem_to_reg`=1 in state 4; 7 cycles total.
- BEQ (0x04) then J (0x02) → `pc_write_cond`=1 with `pc_source`=01 in state 10, `pc_write`=1 with `pc_source`=10 in state 11; count +2.
- ANDI (0x0C) with SUPPORT_IMM=1 → `alu_op`=11 in state 8. With SUPPORT_IMM=0 → `illegal_op` pulse in DECODE, back to FETCH, count unchanged.
- MEM_HANDSHAKE=0 with `mem_ready` tied 0 → SW (0x2B) completes in 4 cycles.
- Counter and reset: CNT_W=4, 16 retires → `instr_count` wraps to 0. Assert `reset` in MEM_WR during a wait → next cycle `state`=0, `instr_count`=0, no `instr_done`.
